// File: rtl/route_rr_n_pkg.sv
// Shared defaults and helpers for the round-robin routing stage.
package route_rr_n_pkg;

    localparam int unsigned DEF_NUM_IN    = 2;
    localparam int unsigned DEF_NUM_OUT   = 2;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_HDR_W     = 2;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_AF_THRESH = 3;
    localparam int unsigned DEF_AE_THRESH = 1;

    // Index width that stays >= 1 even for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin successor: the port after the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/route_rr_n_arbiter.sv
// Rotating-priority arbiter: search starts at ptr, ascends and wraps; one-hot grant.
module route_rr_n_arbiter
    import route_rr_n_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_w(N)
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c,
    output logic          grant_any_c
);

    int unsigned      pos;
    logic [IW-1:0]    idx;

    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        grant_any_c = 1'b0;
        pos         = 0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            idx = IW'(pos);
            if (!grant_any_c && req[idx]) begin
                grant_any_c  = 1'b1;
                grant_c[idx] = 1'b1;
                grant_idx_c  = idx;
            end
        end
    end

endmodule

// File: rtl/route_rr_n.sv
// NUM_IN x NUM_OUT header-steered router: per-output round-robin arbitration into
// per-output FIFOs, with either valid/ready backpressure or drop-on-full behaviour.
module route_rr_n
    import route_rr_n_pkg::*;
#(
    parameter int unsigned NUM_IN       = DEF_NUM_IN,
    parameter int unsigned NUM_OUT      = DEF_NUM_OUT,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned HDR_W        = DEF_HDR_W,
    parameter int unsigned DEPTH        = DEF_DEPTH,
    parameter int unsigned AF_THRESH    = DEF_AF_THRESH,
    parameter int unsigned AE_THRESH    = DEF_AE_THRESH,
    parameter bit          BACKPRESSURE = 1'b1
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_IN*(HDR_W+DATA_W)-1:0] in_data,
    input  logic [NUM_IN-1:0]                in_valid,
    output logic [NUM_IN-1:0]                in_ready,
    input  logic [NUM_OUT-1:0]               read,
    output logic [NUM_OUT*DATA_W-1:0]        out_data,
    output logic [NUM_OUT-1:0]               out_valid,
    output logic [NUM_OUT-1:0]               empty,
    output logic [NUM_OUT-1:0]               full,
    output logic [NUM_OUT-1:0]               almost_full,
    output logic [NUM_OUT-1:0]               almost_empty,
    output logic [NUM_OUT-1:0]               pause,
    output logic [NUM_OUT-1:0]               error
);

    localparam int unsigned DEST_W = idx_w(NUM_OUT);
    localparam int unsigned WORD_W = HDR_W + DATA_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned AW     = idx_w(DEPTH);
    localparam int unsigned IW     = idx_w(NUM_IN);

    logic [DEST_W-1:0] dest    [NUM_IN];
    logic [DATA_W-1:0] payload [NUM_IN];
    logic [NUM_IN-1:0] grant     [NUM_OUT];
    logic [IW-1:0]     grant_idx [NUM_OUT];
    logic [NUM_OUT-1:0] grant_any;
    logic [NUM_OUT-1:0] wr_en;
    logic [NUM_OUT-1:0] rd_en;
    logic               unused_in;

    // Header bits above the dest field are intentionally ignored.
    assign unused_in = ^in_data;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        assign payload[i] = in_data[i*WORD_W +: DATA_W];
        assign dest[i]    = in_data[i*WORD_W + DATA_W +: DEST_W];
    end

    // Acceptance is combinational so the source can advance in the same cycle.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (reset) begin
                if (BACKPRESSURE)
                    in_ready[i] = in_valid[i] && grant[dest[i]][i] && !full[dest[i]];
                else
                    in_ready[i] = 1'b1;
            end
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_out
        logic [NUM_IN-1:0] req;
        logic [IW-1:0]     rr_ptr;
        logic [CNT_W-1:0]  cnt;
        logic [AW-1:0]     wr_ptr;
        logic [AW-1:0]     rd_ptr;
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_data;
        logic              rd_vld;
        logic              err;

        always_comb begin
            req = '0;
            for (int unsigned i = 0; i < NUM_IN; i++)
                req[i] = in_valid[i] && (dest[i] == DEST_W'(o));
        end

        route_rr_n_arbiter #(.N(NUM_IN)) u_arb (
            .req         (req),
            .ptr         (rr_ptr),
            .grant_c     (grant[o]),
            .grant_idx_c (grant_idx[o]),
            .grant_any_c (grant_any[o])
        );

        // A full FIFO never accepts; in drop mode the refused word becomes an error.
        assign wr_en[o] = grant_any[o] && !full[o];
        assign rd_en[o] = read[o] && !empty[o];

        always_ff @(posedge clk) begin
            if (!reset) begin
                rr_ptr  <= '0;
                cnt     <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                rd_data <= '0;
                rd_vld  <= 1'b0;
                err     <= 1'b0;
            end else begin
                if (wr_en[o]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rr_ptr <= IW'(rr_next(32'(grant_idx[o]), NUM_IN));
                end
                if (rd_en[o]) begin
                    rd_ptr  <= rd_ptr + AW'(1);
                    rd_data <= mem[rd_ptr];
                end
                rd_vld <= rd_en[o];
                cnt    <= cnt + CNT_W'(wr_en[o]) - CNT_W'(rd_en[o]);
                if ((read[o] && empty[o]) || (!BACKPRESSURE && grant_any[o] && full[o]))
                    err <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (wr_en[o])
                mem[wr_ptr] <= payload[grant_idx[o]];
        end

        assign empty[o]                     = (cnt == '0);
        assign full[o]                      = (cnt == CNT_W'(DEPTH));
        assign almost_full[o]               = (cnt >= CNT_W'(AF_THRESH));
        assign almost_empty[o]              = (cnt <= CNT_W'(AE_THRESH));
        assign pause[o]                     = almost_full[o];
        assign error[o]                     = err;
        assign out_valid[o]                 = rd_vld;
        assign out_data[o*DATA_W +: DATA_W] = rd_data;
    end

endmodule

// File: tb/tb_route_rr_n.sv
// Directed bench for route_rr_n: a backpressure instance and a drop-on-full instance.
module tb_route_rr_n;

    logic        clk;
    logic        reset;

    logic [19:0] in_data;
    logic [1:0]  in_valid, in_ready, read;
    logic [15:0] out_data;
    logic [1:0]  out_valid, empty, full, almost_full, almost_empty, pause, error;

    logic [19:0] nb_in_data;
    logic [1:0]  nb_in_valid, nb_in_ready, nb_read;
    logic [15:0] nb_out_data;
    logic [1:0]  nb_out_valid, nb_empty, nb_full, nb_almost_full, nb_almost_empty, nb_pause, nb_error;

    int tests;
    int fails;

    route_rr_n #(
        .NUM_IN(2), .NUM_OUT(2), .DATA_W(8), .HDR_W(2), .DEPTH(4),
        .AF_THRESH(3), .AE_THRESH(1), .BACKPRESSURE(1'b1)
    ) dut_bp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .read(read), .out_data(out_data), .out_valid(out_valid),
        .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .pause(pause), .error(error)
    );

    route_rr_n #(
        .NUM_IN(2), .NUM_OUT(2), .DATA_W(8), .HDR_W(2), .DEPTH(4),
        .AF_THRESH(3), .AE_THRESH(1), .BACKPRESSURE(1'b0)
    ) dut_nb (
        .clk(clk), .reset(reset), .in_data(nb_in_data), .in_valid(nb_in_valid),
        .in_ready(nb_in_ready), .read(nb_read), .out_data(nb_out_data), .out_valid(nb_out_valid),
        .empty(nb_empty), .full(nb_full), .almost_full(nb_almost_full),
        .almost_empty(nb_almost_empty), .pause(nb_pause), .error(nb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] w(input logic [1:0] h, input logic [7:0] d);
        return {h, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 2'b11;
        in_data  = {w(2'b00, 8'h11), w(2'b01, 8'h22)};
        nb_in_valid = 2'b11;
        repeat (3) tick();
        tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL reset_in_ready got %b exp 00", in_ready); end
        tests++; if (nb_in_ready !== 2'b00) begin fails++; $display("FAIL reset_nb_in_ready got %b exp 00", nb_in_ready); end
        tests++; if (empty !== 2'b11) begin fails++; $display("FAIL reset_empty got %b exp 11", empty); end
        tests++; if (almost_empty !== 2'b11) begin fails++; $display("FAIL reset_almost_empty got %b exp 11", almost_empty); end
        tests++; if (full !== 2'b00 || almost_full !== 2'b00 || pause !== 2'b00) begin
            fails++; $display("FAIL reset_full_af got full=%b af=%b pause=%b exp 00", full, almost_full, pause); end
        tests++; if (out_data !== 16'h0000 || out_valid !== 2'b00) begin
            fails++; $display("FAIL reset_out got data=%h valid=%b exp 0000/00", out_data, out_valid); end
        tests++; if (error !== 2'b00) begin fails++; $display("FAIL reset_error got %b exp 00", error); end
        in_valid    = 2'b00;
        nb_in_valid = 2'b00;
        reset       = 1'b1;
    endtask

    task automatic test_single();
        in_data  = {w(2'b00, 8'h00), w(2'b01, 8'hA5)};
        in_valid = 2'b01;
        #1;
        tests++; if (in_ready !== 2'b01) begin fails++; $display("FAIL single_in_ready got %b exp 01", in_ready); end
        tick();
        in_valid = 2'b00;
        tests++; if (empty !== 2'b01) begin fails++; $display("FAIL single_empty got %b exp 01", empty); end
        read = 2'b10;
        tick();
        read = 2'b00;
        tests++; if (out_data[15:8] !== 8'hA5 || out_valid !== 2'b10) begin
            fails++; $display("FAIL single_pop got data=%h valid=%b exp A5/10", out_data[15:8], out_valid); end
        tick();
        tests++; if (out_valid !== 2'b00) begin fails++; $display("FAIL single_valid_drop got %b exp 00", out_valid); end
    endtask

    task automatic test_rr();
        int   acc0;
        int   acc1;
        logic [1:0] exp_rdy;
        acc0 = 0;
        acc1 = 0;
        for (int c = 0; c < 4; c++) begin
            in_data  = {w(2'b00, 8'h11 + 8'(acc1)), w(2'b00, 8'h01 + 8'(acc0))};
            in_valid = 2'b11;
            exp_rdy  = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++; if (in_ready !== exp_rdy) begin
                fails++; $display("FAIL rr_grant[%0d] got %b exp %b", c, in_ready, exp_rdy); end
            tick();
            if (exp_rdy[0]) acc0++; else acc1++;
            tests++; if (almost_full[0] !== (c >= 2) || pause[0] !== (c >= 2) || full[0] !== (c == 3)) begin
                fails++; $display("FAIL rr_status[%0d] got af=%b pause=%b full=%b exp af=%b full=%b",
                                  c, almost_full[0], pause[0], full[0], (c >= 2), (c == 3)); end
        end
        in_valid = 2'b00;
    endtask

    task automatic test_full_block();
        logic [7:0] exp_pop [4];
        exp_pop = '{8'h01, 8'h11, 8'h02, 8'h12};
        in_data  = {w(2'b01, 8'h99), w(2'b00, 8'h77)};
        in_valid = 2'b11;
        #1;
        tests++; if (in_ready !== 2'b10) begin fails++; $display("FAIL full_in_ready got %b exp 10", in_ready); end
        tick();
        in_valid = 2'b00;
        tests++; if (empty !== 2'b00 || full !== 2'b01 || error !== 2'b00) begin
            fails++; $display("FAIL full_state got empty=%b full=%b error=%b exp 00/01/00", empty, full, error); end
        for (int k = 0; k < 4; k++) begin
            read = (k == 0) ? 2'b11 : 2'b01;
            tick();
            tests++; if (out_data[7:0] !== exp_pop[k] || out_valid[0] !== 1'b1) begin
                fails++; $display("FAIL full_pop[%0d] got %h/%b exp %h/1", k, out_data[7:0], out_valid[0], exp_pop[k]); end
            if (k == 0) begin
                tests++; if (out_data[15:8] !== 8'h99 || out_valid[1] !== 1'b1) begin
                    fails++; $display("FAIL full_pop1 got %h/%b exp 99/1", out_data[15:8], out_valid[1]); end
            end
        end
        read = 2'b00;
        tests++; if (empty !== 2'b11 || error !== 2'b00) begin
            fails++; $display("FAIL full_drained got empty=%b error=%b exp 11/00", empty, error); end
    endtask

    task automatic test_rw_same();
        in_data  = {w(2'b00, 8'h00), w(2'b01, 8'h31)};
        in_valid = 2'b01;
        tick();
        in_data  = {w(2'b00, 8'h00), w(2'b01, 8'h32)};
        read     = 2'b10;
        tick();
        in_valid = 2'b00;
        tests++; if (out_data[15:8] !== 8'h31 || out_valid !== 2'b10) begin
            fails++; $display("FAIL rw_pop got %h/%b exp 31/10", out_data[15:8], out_valid); end
        tests++; if (empty[1] !== 1'b0 || almost_empty[1] !== 1'b1) begin
            fails++; $display("FAIL rw_count got empty=%b ae=%b exp 0/1", empty[1], almost_empty[1]); end
        tick();
        read = 2'b00;
        tests++; if (out_data[15:8] !== 8'h32 || empty[1] !== 1'b1) begin
            fails++; $display("FAIL rw_second got %h empty=%b exp 32/1", out_data[15:8], empty[1]); end
    endtask

    task automatic test_drop();
        for (int k = 0; k < 5; k++) begin
            nb_in_data  = {w(2'b00, 8'h00), w(2'b00, 8'h41 + 8'(k))};
            nb_in_valid = 2'b01;
            #1;
            tests++; if (nb_in_ready !== 2'b11) begin
                fails++; $display("FAIL drop_ready[%0d] got %b exp 11", k, nb_in_ready); end
            tick();
            if (k == 3) begin
                tests++; if (nb_full !== 2'b01 || nb_error !== 2'b00) begin
                    fails++; $display("FAIL drop_filled got full=%b error=%b exp 01/00", nb_full, nb_error); end
            end
        end
        nb_in_valid = 2'b00;
        tests++; if (nb_error !== 2'b01) begin fails++; $display("FAIL drop_error got %b exp 01", nb_error); end
        for (int k = 0; k < 4; k++) begin
            nb_read = 2'b01;
            tick();
            tests++; if (nb_out_data[7:0] !== 8'h41 + 8'(k)) begin
                fails++; $display("FAIL drop_pop[%0d] got %h exp %h", k, nb_out_data[7:0], 8'h41 + 8'(k)); end
        end
        nb_read = 2'b00;
        tests++; if (nb_empty[0] !== 1'b1 || nb_error !== 2'b01) begin
            fails++; $display("FAIL drop_after got empty=%b error=%b exp 1/01", nb_empty[0], nb_error); end
    endtask

    task automatic test_empty_read();
        read = 2'b01;
        tick();
        read = 2'b00;
        tests++; if (error !== 2'b01 || out_valid[0] !== 1'b0 || out_data[7:0] !== 8'h12) begin
            fails++; $display("FAIL empty_read got error=%b valid=%b data=%h exp 01/0/12", error, out_valid[0], out_data[7:0]); end
        for (int k = 0; k < 2; k++) begin
            in_data  = {w(2'b00, 8'h00), w(2'b00, 8'h51 + 8'(k))};
            in_valid = 2'b01;
            tick();
        end
        in_valid = 2'b00;
        tests++; if (empty[0] !== 1'b0) begin fails++; $display("FAIL pre_reset_empty got %b exp 0", empty[0]); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests++; if (empty !== 2'b11 || full !== 2'b00 || error !== 2'b00 || out_data !== 16'h0000) begin
            fails++; $display("FAIL mid_reset got empty=%b full=%b error=%b data=%h exp 11/00/00/0000",
                              empty, full, error, out_data); end
        tests++; if (nb_error !== 2'b00 || nb_out_data !== 16'h0000) begin
            fails++; $display("FAIL nb_reset got error=%b data=%h exp 00/0000", nb_error, nb_out_data); end
        in_data  = {w(2'b00, 8'h61), w(2'b00, 8'h60)};
        in_valid = 2'b11;
        #1;
        tests++; if (in_ready !== 2'b01) begin fails++; $display("FAIL rr_reset got %b exp 01", in_ready); end
        in_valid = 2'b00;
        tick();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b0;
        in_data     = '0;
        in_valid    = '0;
        read        = '0;
        nb_in_data  = '0;
        nb_in_valid = '0;
        nb_read     = '0;
        test_reset();
        test_single();
        test_rr();
        test_full_block();
        test_rw_same();
        test_drop();
        test_empty_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
